// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths and FSM state type for the sequential 8-to-3 encoder
package enc_pkg;
   localparam int VEC_W = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } enc_state_t;
endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8-bit priority encoder with any/single flags
module prio_enc8
   import enc_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic [VEC_W-1:0] pending,
   output logic [IDX_W-1:0] idx,
   output logic             any,
   output logic             single
);

   // Later loop iterations override earlier ones, so the scan direction sets priority.
   always_comb begin
      idx = '0;
      if (LSB_FIRST) begin
         for (int i = VEC_W - 1; i >= 0; i--) begin
            if (pending[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < VEC_W; i++) begin
            if (pending[i]) idx = IDX_W'(i);
         end
      end
   end

   assign any    = |pending;
   assign single = any && ((pending & (pending - VEC_W'(1))) == '0);

endmodule

// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - accepts a request vector and emits its set-bit indices one per transfer
module encoder_8to3_seq
   import enc_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [VEC_W-1:0] in_vec,
   output logic             in_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] idx,
   output logic             out_last,
   input  logic             out_ready,
   output logic             zero_drop
);

   enc_state_t       state_q, state_d;
   logic [VEC_W-1:0] pending_q, pending_d;
   logic             zero_drop_q, zero_drop_d;

   logic [IDX_W-1:0] enc_idx;
   logic             enc_any;
   logic             enc_single;

   prio_enc8 #(
      .LSB_FIRST (LSB_FIRST)
   ) u_prio (
      .pending (pending_q),
      .idx     (enc_idx),
      .any     (enc_any),
      .single  (enc_single)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         zero_drop_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         zero_drop_q <= zero_drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      zero_drop_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (|in_vec) begin
                  pending_d = in_vec;
                  state_d   = EMIT;
               end else begin
                  zero_drop_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~(VEC_W'(1) << enc_idx);
               if (enc_single) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs come only from registered state; out_ready never reaches idx or out_last.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == EMIT) && enc_any;
   assign idx       = out_valid ? enc_idx : '0;
   assign out_last  = out_valid && enc_single;
   assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - scoreboard bench for encoder_8to3_seq in both priority orders
module tb_encoder_8to3_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_vec = '0;
   logic       out_ready = 1'b1;

   logic       in_valid0 = 1'b0, in_ready0, out_valid0, out_last0, zero_drop0;
   logic [2:0] idx0;
   logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_last1, zero_drop1;
   logic [2:0] idx1;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [3:0] q0[$];
   logic [3:0] q1[$];

   logic       stall0 = 1'b0, stall1 = 1'b0;
   logic [3:0] held0, held1;

   always #5 clk = ~clk;

   encoder_8to3_seq #(.LSB_FIRST(1'b0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid0),
      .in_vec    (in_vec),
      .in_ready  (in_ready0),
      .out_valid (out_valid0),
      .idx       (idx0),
      .out_last  (out_last0),
      .out_ready (out_ready),
      .zero_drop (zero_drop0)
   );

   encoder_8to3_seq #(.LSB_FIRST(1'b1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_vec    (in_vec),
      .in_ready  (in_ready1),
      .out_valid (out_valid1),
      .idx       (idx1),
      .out_last  (out_last1),
      .out_ready (out_ready),
      .zero_drop (zero_drop1)
   );

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   // Monitor: pops expected {last, idx} on every transfer and checks stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall0 <= 1'b0;
         stall1 <= 1'b0;
      end else begin
         if (stall0 && out_valid0) check("hold0", {out_last0, idx0}, held0);
         if (stall1 && out_valid1) check("hold1", {out_last1, idx1}, held1);
         if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
               total_cnt++;
               $display("FAIL q0_unexpected actual idx=%0d required none", idx0);
            end else begin
               check("idx0", {out_last0, idx0}, q0.pop_front());
            end
         end
         if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
               total_cnt++;
               $display("FAIL q1_unexpected actual idx=%0d required none", idx1);
            end else begin
               check("idx1", {out_last1, idx1}, q1.pop_front());
            end
         end
         stall0 <= out_valid0 && !out_ready;
         stall1 <= out_valid1 && !out_ready;
         held0  <= {out_last0, idx0};
         held1  <= {out_last1, idx1};
      end
   end

   // Called just after a posedge; holds in_valid across hold_edges rising edges.
   task automatic send(input logic [7:0] vec, input int lane, input int hold_edges);
      in_vec = vec;
      if (lane == 0) in_valid0 = 1'b1;
      else in_valid1 = 1'b1;
      repeat (hold_edges) @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (!(in_ready0 && in_ready1 && q0.size() == 0 && q1.size() == 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, q0.size() + q1.size(), 0);
      check({name, "_idle"}, in_ready0 && in_ready1, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_in_ready", in_ready0, 1);
      check("rst_out_valid", out_valid0, 0);
      check("rst_idx", idx0, 0);
      check("rst_out_last", out_last0, 0);
      check("rst_zero_drop", zero_drop0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single bit
      q0.push_back({1'b1, 3'd5});
      send(8'h20, 0, 1);
      check("single_latency", out_valid0, 1);
      check("single_idx", idx0, 5);
      check("single_last", out_last0, 1);
      @(posedge clk);
      #1;
      check("single_ready_again", in_ready0, 1);
      wait_idle("single");

      // multi-hot MSB first; in_valid held so the vector is re-accepted at the earliest legal edge
      repeat (2) begin
         q0.push_back({1'b0, 3'd7});
         q0.push_back({1'b0, 3'd2});
         q0.push_back({1'b1, 3'd0});
      end
      send(8'b1000_0101, 0, 5);
      wait_idle("msb_first");

      // multi-hot LSB first
      q1.push_back({1'b0, 3'd0});
      q1.push_back({1'b0, 3'd2});
      q1.push_back({1'b1, 3'd7});
      send(8'b1000_0101, 1, 1);
      wait_idle("lsb_first");

      // backpressure
      for (int i = 7; i >= 0; i--) q0.push_back({(i == 0), 3'(i)});
      out_ready = 1'b1;
      send(8'hFF, 0, 1);
      for (int k = 0; k < 30; k++) begin
         out_ready = (k % 3 == 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_idle("backpressure");

      // zero vector
      send(8'h00, 0, 1);
      check("zero_drop_pulse", zero_drop0, 1);
      check("zero_out_valid", out_valid0, 0);
      check("zero_in_ready", in_ready0, 1);
      @(posedge clk);
      #1;
      check("zero_drop_one_cycle", zero_drop0, 0);
      check("zero_out_valid_after", out_valid0, 0);

      // reset mid-emit
      q0.push_back({1'b0, 3'd7});
      send(8'hF0, 0, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid0, 0);
      check("midrst_in_ready", in_ready0, 1);
      check("midrst_idx", idx0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("post_rst_quiet", out_valid0, 0);
      end
      check("midrst_q_drained", q0.size(), 0);
      q0.push_back({1'b1, 3'd0});
      send(8'h01, 0, 1);
      wait_idle("after_reset");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
